lcd_bus_writer: RTL

//  Downstream stage of the LCD command generator. Buffers (data byte, dcx) pairs in a small FIFO.

---
 rtl/lcd_bus_writer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_writer.sv
// Write-only 8080-style parallel bus driver for ILI9341-class panels.
// Bytes queue as {dcx,data}; the FSM frames them with csx and strobes each one on wrx.
module lcd_bus_writer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int CS_IDLE_CYC = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  input  logic                          in_dcx,
  output logic                          in_ready,
  output logic [7:0]                    lcd_d,
  output logic                          lcd_dcx,
  output logic                          lcd_wrx,
  output logic                          lcd_csx,
  output logic                          lcd_rdx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int LW      = PW + 1;
  localparam int MAX_LH  = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
  localparam int MAX_CYC = (MAX_LH > CS_IDLE_CYC) ? MAX_LH : CS_IDLE_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] LOW_LAST  = CW'(WR_LOW_CYC - 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(WR_HIGH_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(CS_IDLE_CYC - 1);
  localparam logic [LW-1:0] DEPTH     = LW'(FIFO_DEPTH);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CS_SETUP = 3'd1;
  localparam logic [2:0] WR_LOW   = 3'd2;
  localparam logic [2:0] WR_HIGH  = 3'd3;
  localparam logic [2:0] CS_HOLD  = 3'd4;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [LW-1:0] count_reg;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [2:0]    state_reg;
  logic [2:0]    state_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          wrx_reg;
  logic          wrx_next;
  logic          csx_reg;
  logic          csx_next;
  logic [7:0]    d_reg;
  logic          dcx_reg;

  // Readiness comes from the registered count only, so a same-cycle pop never frees a full slot.
  assign full     = (count_reg == DEPTH);
  assign empty    = (count_reg == '0);
  assign in_ready = ~full & ~rst;
  assign push     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_dcx, in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Every move into WR_LOW pops the head; the data registers load on that same edge.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wrx_next   = wrx_reg;
    csx_next   = csx_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        csx_next = 1'b1;
        wrx_next = 1'b1;
        cnt_next = '0;
        if (!empty) begin
          state_next = CS_SETUP;
          csx_next   = 1'b0;
        end
      end
      CS_SETUP: begin
        state_next = WR_LOW;
        pop        = 1'b1;
        wrx_next   = 1'b0;
        cnt_next   = '0;
      end
      WR_LOW: begin
        if (cnt_reg == LOW_LAST) begin
          state_next = WR_HIGH;
          wrx_next   = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WR_HIGH: begin
        if (cnt_reg == HIGH_LAST) begin
          cnt_next = '0;
          if (!empty) begin
            state_next = WR_LOW;
            pop        = 1'b1;
            wrx_next   = 1'b0;
          end else begin
            state_next = CS_HOLD;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      CS_HOLD: begin
        if (!empty) begin
          state_next = WR_LOW;
          pop        = 1'b1;
          wrx_next   = 1'b0;
          cnt_next   = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next = IDLE;
          csx_next   = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        csx_next   = 1'b1;
        wrx_next   = 1'b1;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      wrx_reg   <= 1'b1;
      csx_reg   <= 1'b1;
      d_reg     <= 8'h00;
      dcx_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wrx_reg   <= wrx_next;
      csx_reg   <= csx_next;
      if (pop) begin
        d_reg   <= mem[rd_ptr_reg][7:0];
        dcx_reg <= mem[rd_ptr_reg][8];
      end
    end
  end

  assign lcd_d      = d_reg;
  assign lcd_dcx    = dcx_reg;
  assign lcd_wrx    = wrx_reg;
  assign lcd_csx    = csx_reg;
  assign lcd_rdx    = 1'b1;
  assign fifo_level = count_reg;
  assign busy       = (state_reg != IDLE) | ~empty;

endmodule
